// File: rtl/ps2_letter_input.sv
// PS/2 keyboard receiver for the enigma letter path: filters the keyboard clock,
// deframes bytes and turns set-2 make/break codes for A-Z into a held one-hot letter.
module ps2_letter_input #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [25:0] letter_out,
    output logic        key_valid,
    output logic        key_press,
    output logic        frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    // Set-2 make codes, bit 25 (Z) in the top byte down to bit 0 (A).
    localparam logic [26*8-1:0] LETTER_CODES = {
        8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D,
        8'h15, 8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43,
        8'h33, 8'h34, 8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
    };

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PARITY,
        F_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        C_NORMAL,
        C_BREAK,
        C_EXT,
        C_EXT_BREAK
    } code_state_t;

    logic               clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic               dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic               filt_q, filt_d;
    logic [FCW-1:0]     filt_cnt_q, filt_cnt_d;
    logic               fall;

    frame_state_t       fstate_q, fstate_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic [TCW-1:0]     to_cnt_q, to_cnt_d;
    logic               byte_rdy_q, byte_rdy_d;
    logic               frame_err_q, frame_err_d;

    code_state_t        cstate_q, cstate_d;
    logic [25:0]        letter_q, letter_d;
    logic               key_press_q, key_press_d;
    logic [25:0]        letter_hit;

    always_comb begin
        clk_s1_d = PS2_CLK;
        clk_s2_d = clk_s1_q;
        dat_s1_d = PS2_DAT;
        dat_s2_d = dat_s1_q;
    end

    // The filtered clock only follows the synchronised clock once it has
    // disagreed for FILTER_LEN samples in a row; any agreeing sample restarts.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fall   = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end
    end

    always_comb begin
        fstate_d    = fstate_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        to_cnt_d    = to_cnt_q;
        byte_rdy_d  = 1'b0;
        frame_err_d = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            case (fstate_q)
                F_IDLE: begin
                    if (!dat_s2_q) begin
                        fstate_d  = F_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                F_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        fstate_d = F_PARITY;
                    end
                end
                F_PARITY: begin
                    parity_d = dat_s2_q;
                    fstate_d = F_STOP;
                end
                F_STOP: begin
                    // Parity and stop bit are judged together so a bad frame reports once.
                    fstate_d = F_IDLE;
                    if (dat_s2_q && ((^shift_q) ^ parity_q)) begin
                        byte_rdy_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: fstate_d = F_IDLE;
            endcase
        end else if (fstate_q != F_IDLE) begin
            if (to_cnt_q == TCW'(TIMEOUT - 1)) begin
                fstate_d    = F_IDLE;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TCW'(1);
            end
        end
    end

    // Codes are unique, so letter_hit is one-hot for a letter and zero otherwise.
    generate
        for (genvar gi = 0; gi < 26; gi++) begin : g_letter
            assign letter_hit[gi] = (shift_q == LETTER_CODES[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        cstate_d    = cstate_q;
        letter_d    = letter_q;
        key_press_d = 1'b0;
        if (byte_rdy_q) begin
            case (cstate_q)
                C_NORMAL: begin
                    if (shift_q == 8'hF0) begin
                        cstate_d = C_BREAK;
                    end else if (shift_q == 8'hE0) begin
                        cstate_d = C_EXT;
                    end else if ((letter_q == '0) && (|letter_hit)) begin
                        letter_d    = letter_hit;
                        key_press_d = 1'b1;
                    end
                end
                C_BREAK: begin
                    cstate_d = C_NORMAL;
                    if ((|letter_q) && (letter_hit == letter_q)) begin
                        letter_d = '0;
                    end
                end
                C_EXT: begin
                    cstate_d = (shift_q == 8'hF0) ? C_EXT_BREAK : C_NORMAL;
                end
                default: cstate_d = C_NORMAL;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            fstate_q    <= F_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            byte_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cstate_q    <= C_NORMAL;
            letter_q    <= '0;
            key_press_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            fstate_q    <= fstate_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            byte_rdy_q  <= byte_rdy_d;
            frame_err_q <= frame_err_d;
            cstate_q    <= cstate_d;
            letter_q    <= letter_d;
            key_press_q <= key_press_d;
        end
    end

    assign letter_out = letter_q;
    assign key_valid  = |letter_q;
    assign key_press  = key_press_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_letter_input.sv
// Bench for ps2_letter_input: serialises PS/2 frames, queues the expected
// press/release/error events and checks them as the DUT produces them.
module tb_ps2_letter_input;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 4500;
    localparam int FAST       = 30;
    localparam int SLOW       = 2000;
    // 2 synchroniser stages, FILTER_LEN filter samples (last one also loads byte_rdy), letter register.
    localparam int PRESS_LAT  = 2 + FILTER_LEN + 1;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [25:0] letter_out;
    logic        key_valid;
    logic        key_press;
    logic        frame_err;

    ps2_letter_input #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .letter_out(letter_out),
        .key_valid (key_valid),
        .key_press (key_press),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_NONE, EV_PRESS, EV_RELEASE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [25:0] letter;
    } ev_t;
    typedef struct {
        logic [7:0]  data;
        bit          perr;
        bit          sbad;
        ev_kind_t    ev;
        logic [25:0] letter;
    } vec_t;

    ev_t         exp_q[$];
    ev_t         mon_e;
    logic [25:0] prev_letter = '0;
    int          n_checks    = 0;
    int          n_fail      = 0;
    int          stop_cyc    = 0;
    int          n_err_seen  = 0;
    int          n_press_seen = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [25:0] l);
        ev_t e;
        e.kind   = k;
        e.letter = l;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] data, input bit perr, input bit sbad,
                             input int nbits, input int half);
        logic [10:0] bits;
        bits = {~sbad, (~^data) ^ perr, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0, name, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(letter_out == '0, {name, "_letter"}, letter_out, 0);
        check(key_valid == 1'b0, {name, "_valid"}, key_valid, 0);
        check(key_press == 1'b0, {name, "_press"}, key_press, 0);
        check(frame_err == 1'b0, {name, "_err"}, frame_err, 0);
    endtask

    // Event monitor: every press, letter change and frame error must match the queue head.
    always @(negedge clk) begin
        check(key_valid == (|letter_out), "key_valid_tracks", key_valid, |letter_out);
        check(!(key_press && frame_err), "press_err_exclusive", {key_press, frame_err}, 0);
        if (key_press) begin
            n_press_seen++;
            check(exp_q.size() != 0, "unexpected_press", letter_out, 0);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check(mon_e.kind == EV_PRESS && prev_letter == '0, "press_kind", 32'(mon_e.kind), 32'(EV_PRESS));
                check(letter_out == mon_e.letter, "press_letter", letter_out, mon_e.letter);
                check(cyc - stop_cyc == PRESS_LAT, "press_latency", cyc - stop_cyc, PRESS_LAT);
            end
        end else if (letter_out != prev_letter) begin
            check(exp_q.size() != 0, "unexpected_letter_change", letter_out, prev_letter);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check(mon_e.kind == EV_RELEASE && letter_out == '0, "release", letter_out, 0);
            end
        end
        if (frame_err) begin
            n_err_seen++;
            check(exp_q.size() != 0, "unexpected_frame_err", frame_err, 0);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check(mon_e.kind == EV_ERR, "err_kind", 32'(mon_e.kind), 32'(EV_ERR));
                check(letter_out == prev_letter, "err_letter_hold", letter_out, prev_letter);
            end
        end
        prev_letter = letter_out;
    end

    function automatic vec_t mk(input logic [7:0] d, input bit pe, input bit sb,
                                input ev_kind_t ev, input logic [25:0] l);
        vec_t v;
        v.data = d; v.perr = pe; v.sbad = sb; v.ev = ev; v.letter = l;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int   err0;
        int   press0;

        // typematic repeat then release of A (A held from the first frame)
        vecs.push_back(mk(8'h1C, 0, 0, EV_NONE,    26'h1));
        vecs.push_back(mk(8'h1C, 0, 0, EV_NONE,    26'h1));
        vecs.push_back(mk(8'h1C, 0, 0, EV_NONE,    26'h1));
        vecs.push_back(mk(8'hF0, 0, 0, EV_NONE,    26'h1));
        vecs.push_back(mk(8'h1C, 0, 0, EV_RELEASE, 26'h0));
        // break with nothing held, non-letter make
        vecs.push_back(mk(8'hF0, 0, 0, EV_NONE,    26'h0));
        vecs.push_back(mk(8'h1C, 0, 0, EV_NONE,    26'h0));
        vecs.push_back(mk(8'h16, 0, 0, EV_NONE,    26'h0));
        // first key wins
        vecs.push_back(mk(8'h1A, 0, 0, EV_PRESS,   26'h2000000));
        vecs.push_back(mk(8'h15, 0, 0, EV_NONE,    26'h2000000));
        vecs.push_back(mk(8'hF0, 0, 0, EV_NONE,    26'h2000000));
        vecs.push_back(mk(8'h15, 0, 0, EV_NONE,    26'h2000000));
        vecs.push_back(mk(8'hF0, 0, 0, EV_NONE,    26'h2000000));
        vecs.push_back(mk(8'h1A, 0, 0, EV_RELEASE, 26'h0));
        // parity error, then the good frame
        vecs.push_back(mk(8'h24, 1, 0, EV_ERR,     26'h0));
        vecs.push_back(mk(8'h24, 0, 0, EV_PRESS,   26'h10));
        // a bad stop bit between F0 and the break code leaves the BREAK state intact
        vecs.push_back(mk(8'hF0, 0, 0, EV_NONE,    26'h10));
        vecs.push_back(mk(8'h33, 0, 1, EV_ERR,     26'h10));
        vecs.push_back(mk(8'h24, 0, 0, EV_RELEASE, 26'h0));

        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // A at roughly 12.5 kHz keyboard clock
        press0 = n_press_seen;
        expect_ev(EV_PRESS, 26'h1);
        send_bits(8'h1C, 0, 0, 11, SLOW);
        check(letter_out == 26'h1, "t1_letter", letter_out, 26'h1);
        check(key_valid == 1'b1, "t1_valid", key_valid, 1);
        wait_drained("t1_drain");
        check(n_press_seen - press0 == 1, "t1_press_count", n_press_seen - press0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].ev != EV_NONE) expect_ev(vecs[i].ev, vecs[i].letter);
            send_bits(vecs[i].data, vecs[i].perr, vecs[i].sbad, 11, FAST);
            check(letter_out == vecs[i].letter, $sformatf("row%0d_letter", i), letter_out, vecs[i].letter);
            check(key_valid == (vecs[i].letter != '0), $sformatf("row%0d_valid", i), key_valid, vecs[i].letter != '0);
        end
        wait_drained("table_drain");

        // partial frame aborted by the timeout
        err0 = n_err_seen;
        expect_ev(EV_ERR, 26'h0);
        send_bits(8'h2B, 0, 0, 5, FAST);
        repeat (TIMEOUT + 10) @(negedge clk);
        wait_drained("t5_timeout_drain");
        check(n_err_seen - err0 == 1, "t5_err_count", n_err_seen - err0, 1);
        expect_ev(EV_PRESS, 26'h20);
        send_bits(8'h2B, 0, 0, 11, FAST);
        check(letter_out == 26'h20, "t5_letter", letter_out, 26'h20);
        expect_ev(EV_RELEASE, 26'h0);
        send_bits(8'hF0, 0, 0, 11, FAST);
        send_bits(8'h2B, 0, 0, 11, FAST);
        wait_drained("t5_drain");

        // extended code ignored, clock glitches rejected, reset mid-frame
        press0 = n_press_seen;
        send_bits(8'hE0, 0, 0, 11, FAST);
        send_bits(8'h1C, 0, 0, 11, FAST);
        check(letter_out == '0, "t6_ext_letter", letter_out, 0);
        check(n_press_seen == press0, "t6_ext_no_press", n_press_seen - press0, 0);
        err0 = n_err_seen;
        ps2_dat = 1'b0;
        repeat (4) begin
            ps2_clk = 1'b0;
            repeat (5) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        repeat (TIMEOUT + 10) @(negedge clk);
        ps2_dat = 1'b1;
        check(n_err_seen == err0, "t6_glitch_no_edges", n_err_seen - err0, 0);
        check(n_press_seen == press0, "t6_glitch_no_press", n_press_seen - press0, 0);
        expect_ev(EV_PRESS, 26'h400000);
        send_bits(8'h1D, 0, 0, 11, FAST);
        check(letter_out == 26'h400000, "t6_w_letter", letter_out, 26'h400000);
        send_bits(8'h1C, 0, 0, 3, FAST);
        expect_ev(EV_RELEASE, 26'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("t6_in_reset");
        rst_n = 1'b1;
        err0 = n_err_seen;
        repeat (TIMEOUT + 10) @(negedge clk);
        check_outputs_zero("t6_after_reset");
        check(n_err_seen == err0, "t6_frame_dropped", n_err_seen - err0, 0);
        wait_drained("t6_drain");
        expect_ev(EV_PRESS, 26'h1);
        send_bits(8'h1C, 0, 0, 11, FAST);
        check(letter_out == 26'h1, "t6_recover_letter", letter_out, 26'h1);
        wait_drained("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
